// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and default constants for the IF/LS unified-memory arbiter.
package riscv_mem_pkg;

    localparam int unsigned DEF_AW             = 32;
    localparam int unsigned DEF_DW             = 32;
    localparam int unsigned DEF_STARVE_LIMIT   = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } arb_state_e;

    typedef enum logic {
        GNT_IF,
        GNT_LS
    } grant_e;

    typedef struct packed {
        logic [DEF_AW-1:0]   addr;
        logic                we;
        logic [DEF_DW-1:0]   wdata;
        logic [DEF_DW/8-1:0] be;
    } mem_req_t;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Requester (IF/LS) and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface riscv_mem_arbiter_if
    import riscv_mem_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
);
    logic            if_req_valid;
    logic            if_req_ready;
    logic [AW-1:0]   if_req_addr;
    logic            if_rsp_valid;
    logic [DW-1:0]   if_rsp_rdata;
    logic            if_rsp_err;

    logic            ls_req_valid;
    logic            ls_req_ready;
    logic [AW-1:0]   ls_req_addr;
    logic            ls_req_we;
    logic [DW-1:0]   ls_req_wdata;
    logic [DW/8-1:0] ls_req_be;
    logic            ls_rsp_valid;
    logic [DW-1:0]   ls_rsp_rdata;
    logic            ls_rsp_err;

    logic            mem_valid;
    logic            mem_ready;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_be,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
        output mem_valid, mem_addr, mem_we, mem_wdata, mem_be,
        input  mem_ready, mem_rsp_valid, mem_rdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        output ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_be,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
        input  mem_valid, mem_addr, mem_we, mem_wdata, mem_be,
        output mem_ready, mem_rsp_valid, mem_rdata
    );

endinterface

// File: rtl/riscv_mem_arbiter_prio_sel.sv
// Combinational winner select: LS by default, IF once it has been passed over
// STARVE_LIMIT consecutive times.
module riscv_mem_prio_sel
    import riscv_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned SW           = 3
) (
    input  logic          if_valid,
    input  logic          ls_valid,
    input  logic [SW-1:0] starve_cnt,
    output logic          any_valid,
    output grant_e        pick
);

    logic if_forced;

    assign if_forced = if_valid && (starve_cnt == SW'(STARVE_LIMIT));
    assign any_valid = if_valid || ls_valid;
    assign pick      = (ls_valid && !if_forced) ? GNT_LS : GNT_IF;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Unified single-port memory arbiter for the IF and LS requesters.
// Optional response timeout enabled with `define RISCV_MEM_TIMEOUT_EN.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned AW             = DEF_AW,
    parameter int unsigned DW             = DEF_DW,
    parameter int unsigned STARVE_LIMIT   = DEF_STARVE_LIMIT,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    riscv_mem_arbiter_if.slave  bus
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e      state_q, state_d;
    grant_e          grant_q, pick;
    logic [SW-1:0]   starve_q;
    logic            any_valid, accept, rsp_ok, tmo_hit, done;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [DW-1:0]   wdata_q, done_rdata;
    logic [BW-1:0]   be_q;
    logic            if_rsp_valid_q, ls_rsp_valid_q;
    logic [DW-1:0]   if_rsp_rdata_q, ls_rsp_rdata_q;

    riscv_mem_prio_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_prio_sel (
        .if_valid   (bus.if_req_valid),
        .ls_valid   (bus.ls_req_valid),
        .starve_cnt (starve_q),
        .any_valid  (any_valid),
        .pick       (pick)
    );

`ifdef RISCV_MEM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          stale_q, if_rsp_err_q, ls_rsp_err_q;

    // A response belonging to a timed-out transaction is swallowed once.
    assign rsp_ok  = bus.mem_rsp_valid && !stale_q;
    assign tmo_hit = (state_q == WAIT_RSP) && !rsp_ok && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q        <= '0;
            stale_q      <= 1'b0;
            if_rsp_err_q <= 1'b0;
            ls_rsp_err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == WAIT_RSP) ? tmo_q + 1'b1 : '0;
            if (tmo_hit)
                stale_q <= 1'b1;
            else if (bus.mem_rsp_valid && stale_q)
                stale_q <= 1'b0;
            if (done) begin
                if_rsp_err_q <= (grant_q == GNT_IF) && tmo_hit;
                ls_rsp_err_q <= (grant_q == GNT_LS) && tmo_hit;
            end
        end
    end

    assign bus.if_rsp_err = if_rsp_err_q;
    assign bus.ls_rsp_err = ls_rsp_err_q;
`else
    assign rsp_ok         = bus.mem_rsp_valid;
    assign tmo_hit        = 1'b0;
    assign bus.if_rsp_err = 1'b0;
    assign bus.ls_rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept = reset && any_valid;
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                if (bus.mem_ready) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                done = rsp_ok || tmo_hit;
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_rdata = (we_q || tmo_hit) ? '0 : bus.mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q        <= GNT_IF;
            starve_q       <= '0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            be_q           <= '0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            if_rsp_rdata_q <= '0;
            ls_rsp_rdata_q <= '0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            if (accept) begin
                grant_q <= pick;
                if (pick == GNT_LS) begin
                    addr_q  <= bus.ls_req_addr;
                    we_q    <= bus.ls_req_we;
                    wdata_q <= bus.ls_req_wdata;
                    be_q    <= bus.ls_req_we ? bus.ls_req_be : '1;
                    if (bus.if_req_valid && starve_q != SW'(STARVE_LIMIT))
                        starve_q <= starve_q + 1'b1;
                end else begin
                    addr_q   <= bus.if_req_addr;
                    we_q     <= 1'b0;
                    wdata_q  <= '0;
                    be_q     <= '1;
                    starve_q <= '0;
                end
            end
            if (done) begin
                if (grant_q == GNT_IF) begin
                    if_rsp_valid_q <= 1'b1;
                    if_rsp_rdata_q <= done_rdata;
                end else begin
                    ls_rsp_valid_q <= 1'b1;
                    ls_rsp_rdata_q <= done_rdata;
                end
            end
        end
    end

    assign bus.if_req_ready = accept && (pick == GNT_IF);
    assign bus.ls_req_ready = accept && (pick == GNT_LS);
    assign bus.mem_valid    = (state_q == ISSUE);
    assign bus.mem_addr     = addr_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_be       = be_q;
    assign bus.if_rsp_valid = if_rsp_valid_q;
    assign bus.ls_rsp_valid = ls_rsp_valid_q;
    assign bus.if_rsp_rdata = if_rsp_rdata_q;
    assign bus.ls_rsp_rdata = ls_rsp_rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed-vector bench for riscv_mem_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_riscv_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter_if #(.AW(32), .DW(32)) bus();

    riscv_mem_arbiter #(
        .AW             (32),
        .DW             (32),
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.if_req_valid  = 1'b0;
        bus.if_req_addr   = '0;
        bus.ls_req_valid  = 1'b0;
        bus.ls_req_addr   = '0;
        bus.ls_req_we     = 1'b0;
        bus.ls_req_wdata  = '0;
        bus.ls_req_be     = '0;
        bus.mem_ready     = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    // Called at the first ISSUE negedge; returns at the negedge of the response cycle.
    task automatic serve_from_issue(input logic [31:0] rdata);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready     = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = rdata;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
    endtask

    // 1 = LS, 0 = IF
    logic exp_grant [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state; a valid request must not be accepted while held in reset
        bus.if_req_valid = 1'b1;
        #1;
        check("rst_if_ready", bus.if_req_ready, 0);
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_be", bus.mem_be, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_if_rsp_valid", bus.if_rsp_valid, 0);
        check("rst_ls_rsp_rdata", bus.ls_rsp_rdata, 0);
        check("rst_ls_rsp_err", bus.ls_rsp_err, 0);
        bus.if_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // T1: IF-only read, minimum latency
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h0000_0010;
        #1;
        check("t1_if_ready", bus.if_req_ready, 1);
        check("t1_ls_ready", bus.ls_req_ready, 0);
        @(negedge clk);
        bus.if_req_valid = 1'b0;
        check("t1_mem_valid", bus.mem_valid, 1);
        check("t1_mem_addr", bus.mem_addr, 32'h10);
        check("t1_mem_we", bus.mem_we, 0);
        check("t1_mem_be", bus.mem_be, 4'hF);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("t1_wait_mem_valid", bus.mem_valid, 0);
        check("t1_early_rsp", bus.if_rsp_valid, 0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0010_0093;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("t1_if_rsp_valid", bus.if_rsp_valid, 1);
        check("t1_if_rsp_rdata", bus.if_rsp_rdata, 32'h0010_0093);
        check("t1_ls_rsp_valid", bus.ls_rsp_valid, 0);
        check("t1_if_rsp_err", bus.if_rsp_err, 0);
        @(negedge clk);
        check("t1_rsp_pulse", bus.if_rsp_valid, 0);

        // T2: simultaneous IF read and LS store; LS first, IF back-to-back
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h40;
        bus.ls_req_valid = 1'b1;
        bus.ls_req_addr  = 32'h100;
        bus.ls_req_we    = 1'b1;
        bus.ls_req_wdata = 32'hDEAD_BEEF;
        bus.ls_req_be    = 4'hF;
        #1;
        check("t2_ls_ready", bus.ls_req_ready, 1);
        check("t2_if_ready", bus.if_req_ready, 0);
        @(negedge clk);
        bus.ls_req_valid = 1'b0;
        #1;
        check("t2_mem_we", bus.mem_we, 1);
        check("t2_mem_addr", bus.mem_addr, 32'h100);
        check("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("t2_mem_be", bus.mem_be, 4'hF);
        check("t2_if_ready_issue", bus.if_req_ready, 0);
        serve_from_issue(32'h1234_5678);
        #1;
        check("t2_ls_rsp_valid", bus.ls_rsp_valid, 1);
        check("t2_ls_rsp_rdata", bus.ls_rsp_rdata, 0);
        check("t2_if_rsp_valid", bus.if_rsp_valid, 0);
        check("t2_if_b2b_ready", bus.if_req_ready, 1);
        @(negedge clk);
        bus.if_req_valid = 1'b0;
        check("t2_if_mem_addr", bus.mem_addr, 32'h40);
        check("t2_if_mem_we", bus.mem_we, 0);
        serve_from_issue(32'hCAFE_0001);
        check("t2_if_rsp_valid", bus.if_rsp_valid, 1);
        check("t2_if_rsp_rdata", bus.if_rsp_rdata, 32'hCAFE_0001);
        @(negedge clk);

        // T3: both valid continuously -> LS,LS,LS,LS,IF,LS
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h80;
        bus.ls_req_valid = 1'b1;
        bus.ls_req_addr  = 32'h180;
        bus.ls_req_we    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t3_grant_ls", bus.ls_req_ready, exp_grant[i]);
            check("t3_one_hot", bus.ls_req_ready ^ bus.if_req_ready, 1);
            @(negedge clk);
            serve_from_issue(32'h100 + i);
            #1;
            check("t3_ls_rsp", bus.ls_rsp_valid, exp_grant[i]);
            check("t3_if_rsp", bus.if_rsp_valid, !exp_grant[i]);
        end
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        @(negedge clk);

        // T4: mem_ready withheld for 5 ISSUE cycles
        bus.ls_req_valid = 1'b1;
        bus.ls_req_addr  = 32'h200;
        bus.ls_req_we    = 1'b1;
        bus.ls_req_wdata = 32'hA5A5_5A5A;
        bus.ls_req_be    = 4'b0011;
        #1;
        check("t4_ls_ready", bus.ls_req_ready, 1);
        @(negedge clk);
        bus.ls_req_addr  = 32'h204;
        bus.ls_req_wdata = 32'h0;
        bus.ls_req_be    = 4'hF;
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h44;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_mem_valid", bus.mem_valid, 1);
            check("t4_mem_addr", bus.mem_addr, 32'h200);
            check("t4_mem_we", bus.mem_we, 1);
            check("t4_mem_wdata", bus.mem_wdata, 32'hA5A5_5A5A);
            check("t4_mem_be", bus.mem_be, 4'b0011);
            check("t4_if_ready", bus.if_req_ready, 0);
            check("t4_ls_ready", bus.ls_req_ready, 0);
            @(negedge clk);
        end
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        serve_from_issue(32'h0);
        check("t4_ls_rsp_valid", bus.ls_rsp_valid, 1);
        @(negedge clk);

        // T5: reset in WAIT_RSP, stale response afterwards is ignored
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h300;
        @(negedge clk);
        bus.if_req_valid = 1'b0;
        bus.mem_ready    = 1'b1;
        @(negedge clk);
        bus.mem_ready    = 1'b0;
        reset            = 1'b0;
        bus.if_req_valid = 1'b1;
        #1;
        check("t5_rst_if_ready", bus.if_req_ready, 0);
        check("t5_rst_mem_valid", bus.mem_valid, 0);
        @(negedge clk);
        bus.if_req_valid = 1'b0;
        reset            = 1'b1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0000_0BAD;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("t5_if_rsp_valid", bus.if_rsp_valid, 0);
        check("t5_ls_rsp_valid", bus.ls_rsp_valid, 0);
        check("t5_mem_valid", bus.mem_valid, 0);
        check("t5_if_rsp_rdata", bus.if_rsp_rdata, 0);
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h304;
        #1;
        check("t5_if_ready", bus.if_req_ready, 1);
        @(negedge clk);
        bus.if_req_valid = 1'b0;
        check("t5_mem_addr", bus.mem_addr, 32'h304);
        serve_from_issue(32'h0000_0013);
        check("t5_if_rsp_valid2", bus.if_rsp_valid, 1);
        check("t5_if_rsp_rdata2", bus.if_rsp_rdata, 32'h0000_0013);
        @(negedge clk);

        // T6: slow or missing memory response
        bus.ls_req_valid = 1'b1;
        bus.ls_req_addr  = 32'h400;
        bus.ls_req_we    = 1'b0;
        @(negedge clk);
        bus.ls_req_valid = 1'b0;
        bus.mem_ready    = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
`ifdef RISCV_MEM_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            check("t6_no_rsp_yet", bus.ls_rsp_valid, 0);
            @(negedge clk);
        end
        check("t6_tmo_valid", bus.ls_rsp_valid, 1);
        check("t6_tmo_err", bus.ls_rsp_err, 1);
        check("t6_tmo_rdata", bus.ls_rsp_rdata, 0);
        @(negedge clk);
        check("t6_tmo_pulse", bus.ls_rsp_valid, 0);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0000_0077;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("t6_late_ls", bus.ls_rsp_valid, 0);
        check("t6_late_if", bus.if_rsp_valid, 0);
        check("t6_late_mem_valid", bus.mem_valid, 0);
`else
        for (int k = 0; k < 20; k++) begin
            check("t6_no_rsp_yet", bus.ls_rsp_valid, 0);
            check("t6_err_low", bus.ls_rsp_err, 0);
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0000_0077;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("t6_ls_rsp_valid", bus.ls_rsp_valid, 1);
        check("t6_ls_rsp_rdata", bus.ls_rsp_rdata, 32'h0000_0077);
        check("t6_ls_rsp_err", bus.ls_rsp_err, 0);
`endif
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one unified single-port memory between two requesters of the riscv core: instruction fetch (IF) and load/store unit (LS).
- Arbitrates between them, sequences a single outstanding transaction to the memory, and routes the response back to the granted requester.
- Sits between the core's fetch/LSU interfaces and the memory model; write-back data (WB_Data) is unaffected.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte enables are DW/8 bits).
- STARVE_LIMIT, 4, consecutive LS grants while IF is pending before IF is forced ahead (≥1).
- TIMEOUT_CYCLES, 64, response timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- if_req_valid / ls_req_valid  in  1  request valid.
- if_req_ready / ls_req_ready  out  1  request accepted this cycle.
- if_req_addr / ls_req_addr  in  AW  byte address.
- ls_req_we  in  1  store when 1 (IF is read-only).
- ls_req_wdata  in  DW  store data.
- ls_req_be  in  DW/8  store byte enables.
- if_rsp_valid / ls_rsp_valid  out  1  one-cycle response pulse.
- if_rsp_rdata / ls_rsp_rdata  out  DW  read data (0 for stores).
- if_rsp_err / ls_rsp_err  out  1  response error flag.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts request.
- mem_addr  out  AW  registered address.
- mem_we  out  1  registered write enable.
- mem_wdata  out  DW  registered write data.
- mem_be  out  DW/8  registered byte enables (all ones for reads).
- mem_rsp_valid  in  1  memory response valid.
- mem_rdata  in  DW  memory read data.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT_RSP. At most one transaction in flight.
- IDLE, arbitration:
  - If any req_valid, the winner gets req_ready=1 combinationally in that cycle.
  - The winner's fields are captured into the mem_* registers, along with a 1-bit grant register; next state is ISSUE.
  - Default priority: LS beats IF.
  - If starve_cnt==STARVE_LIMIT and IF is valid, IF wins.
- starve_cnt: increments (saturating) when LS is granted while IF is valid; clears to 0 when IF is granted.
- ISSUE:
  - mem_valid=1 and mem_* are held stable until mem_ready=1; then go to WAIT_RSP.
  - mem_rsp_valid in ISSUE is ignored; memory responds no earlier than the cycle after the handshake.
- WAIT_RSP:
  - On mem_rsp_valid, register mem_rdata (forced to 0 if it was a store) into the granted requester's rsp_rdata.
  - The granted requester's rsp_valid pulses for exactly one cycle on the next edge; state returns to IDLE.
- req_ready is 0 in ISSUE and WAIT_RSP. A new acceptance is possible in the same cycle rsp_valid is high (back-to-back).
- Minimum latency: accept at cycle N → mem_valid at N+1 → (mem_ready at N+1, mem_rsp_valid at N+2) → rsp_valid at N+3.
- Simultaneous valid on both requesters: exactly one is granted. The loser's request must be held stable by its requester and is served at the next IDLE.
- Reset values (asynchronous assertion):
  - state=IDLE, starve_cnt=0, grant=IF.
  - mem_valid=0, mem_addr/wdata=0, mem_be=0, mem_we=0.
  - All rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 while reset is asserted.
- Reset mid-transaction: the in-flight transaction is dropped with no response. A stale mem_rsp_valid arriving in IDLE after reset is ignored.
- rsp_err=0 always unless the optional feature is enabled.

Optional Feature:
- Macro: RISCV_MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RSP.
  - If TIMEOUT_CYCLES cycles elapse without mem_rsp_valid, the granted requester gets rsp_valid=1, rsp_err=1, rsp_rdata=0, and the FSM returns to IDLE.
  - A late mem_rsp_valid for that transaction is discarded; a one-bit "stale" flag swallows exactly one response.
- Undefined: no counter, WAIT_RSP waits indefinitely, rsp_err tied 0.

Decomposition:
- Package riscv_mem_pkg:
  - arb_state_e (IDLE/ISSUE/WAIT_RSP).
  - grant_e (GNT_IF/GNT_LS).
  - mem_req_t struct (addr, we, wdata, be).
  - Default parameter constants.
- One sub-module: riscv_mem_prio_sel, a combinational winner select from the two valids, starve_cnt and STARVE_LIMIT.

Test Plan:
- IF-only read of 0x0000_0010, mem_ready same cycle, mem_rdata=0x0010_0093 one cycle later → if_rsp_valid 3 cycles after acceptance, if_rsp_rdata=0x0010_0093, ls_rsp_valid stays 0.
- Simultaneous IF read 0x40 and LS store 0x100 (wdata 0xDEADBEEF, be 4'b1111) → LS issued first with mem_we=1; ls_rsp_rdata=0; IF is issued next.
- LS valid continuously, IF valid continuously, STARVE_LIMIT=4 → grant sequence LS,LS,LS,LS,IF,LS…
- mem_ready held 0 for 5 cycles in ISSUE → mem_addr/we/wdata/be stable, no req_ready to either requester.
- Reset asserted in WAIT_RSP, then mem_rsp_valid after release → no rsp_valid to either requester; FSM in IDLE; next request served normally.
- With RISCV_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no memory response → ls_rsp_valid=1, ls_rsp_err=1 on the 8th WAIT_RSP cycle; a late response 2 cycles later is ignored.
